// File: rtl/sync_debounce_if.sv
// Level-conditioning bus for sync_debounce: raw asynchronous level in, debounced
// level plus qualification status and rejected-glitch count out.
interface sync_debounce_if #(
  parameter int GLITCH_W = 8
);
  logic                data_in;
  logic                data_out;
  logic                busy;
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (
    output data_in,
    input  data_out,
    input  busy,
    input  glitch_cnt
  );

  modport slave (
    input  data_in,
    output data_out,
    output busy,
    output glitch_cnt
  );
endinterface

// File: rtl/sync_debounce.sv
// Synchronises an asynchronous level into clk and only accepts a new level after it
// holds for DEBOUNCE_CYCLES consecutive cycles; shorter excursions are counted as glitches.
module sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit RESET_VAL       = 1'b0,
  parameter int GLITCH_W        = 8
) (
  input  logic           clk,
  input  logic           rst,
  sync_debounce_if.slave bus
);
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] r_sync_p0;
  logic                   w_sync_q;
  logic [CNT_W-1:0]       r_cnt_p1;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_out_p1;
  logic                   w_out_nxt;
  logic [GLITCH_W-1:0]    r_glitch_p1;
  logic [GLITCH_W-1:0]    w_glitch_nxt;

  // Stage 0: plain flop chain, nothing between stages
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync_p0 <= {r_sync_p0[SYNC_STAGES-2:0], bus.data_in};
    end
  end

  assign w_sync_q = r_sync_p0[SYNC_STAGES-1];

  // Stage 1: a candidate level either completes qualification or falls back (glitch)
  always_comb begin
    w_cnt_nxt    = r_cnt_p1;
    w_out_nxt    = r_out_p1;
    w_glitch_nxt = r_glitch_p1;
    if (w_sync_q == r_out_p1) begin
      w_cnt_nxt = '0;
      if (r_cnt_p1 != '0) begin
        w_glitch_nxt = sat_inc(r_glitch_p1);
      end
    end else if (r_cnt_p1 == CNT_LAST) begin
      w_out_nxt = w_sync_q;
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt_p1 + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_p1    <= '0;
      r_out_p1    <= RESET_VAL;
      r_glitch_p1 <= '0;
    end else begin
      r_cnt_p1    <= w_cnt_nxt;
      r_out_p1    <= w_out_nxt;
      r_glitch_p1 <= w_glitch_nxt;
    end
  end

  assign bus.data_out   = r_out_p1;
  assign bus.busy       = (r_cnt_p1 != '0);
  assign bus.glitch_cnt = r_glitch_p1;
endmodule
